// File: rtl/dvi_timing_gen_if.sv
// rtl/dvi_timing_gen_if.sv - DVI raster timing bundle; pix_ce present with DVI_TIMING_PIXEL_CE_EN
`ifndef NUM_COLS
`define NUM_COLS 640
`endif
`ifndef log2NUM_COLS
`define log2NUM_COLS 10
`endif
`ifndef NUM_ROWS
`define NUM_ROWS 480
`endif
`ifndef log2NUM_ROWS
`define log2NUM_ROWS 9
`endif

interface dvi_timing_gen_if;
`ifdef DVI_TIMING_PIXEL_CE_EN
  logic                       pix_ce;
`endif
  logic [`log2NUM_COLS-1:0]   x;
  logic [`log2NUM_ROWS-1:0]   y;
  logic                       de;
  logic                       hsync;
  logic                       vsync;
  logic                       line_start;
  logic                       frame_start;

  modport master (
`ifdef DVI_TIMING_PIXEL_CE_EN
    input  pix_ce,
`endif
    output x, y, de, hsync, vsync, line_start, frame_start
  );

  modport slave (
`ifdef DVI_TIMING_PIXEL_CE_EN
    output pix_ce,
`endif
    input  x, y, de, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/dvi_timing_gen.sv
// rtl/dvi_timing_gen.sv - DVI raster timing generator (x/y, de, syncs, line/frame markers)
// Optional pixel-advance enable via DVI_TIMING_PIXEL_CE_EN.
module dvi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  dvi_timing_gen_if.master bus
);

  localparam int XW = `log2NUM_COLS;
  localparam int YW = `log2NUM_ROWS;

  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  phase_t     w_h_phase;
  phase_t     w_v_phase;
  logic       w_de;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_adv;

`ifdef DVI_TIMING_PIXEL_CE_EN
  assign w_adv = bus.pix_ce;
`else
  assign w_adv = 1'b1;
`endif

  // Phases are pure decodes of the counters; vertical phase therefore only moves at line wrap.
  always_comb begin
    w_h_phase = PH_ACTIVE;
    w_v_phase = PH_ACTIVE;
    if (r_h_cnt >= H_BP_START)        w_h_phase = PH_BP;
    else if (r_h_cnt >= H_SYNC_START) w_h_phase = PH_SYNC;
    else if (r_h_cnt >= H_FP_START)   w_h_phase = PH_FP;
    if (r_v_cnt >= V_BP_START)        w_v_phase = PH_BP;
    else if (r_v_cnt >= V_SYNC_START) w_v_phase = PH_SYNC;
    else if (r_v_cnt >= V_FP_START)   w_v_phase = PH_FP;
    w_de     = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
    w_h_last = (r_h_cnt == H_LAST);
    w_v_last = (r_v_cnt == V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt         <= '0;
      r_v_cnt         <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.de          <= 1'b0;
      bus.hsync       <= ~SYNC_POL;
      bus.vsync       <= ~SYNC_POL;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (w_adv) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
      // Outputs are decodes of the pre-edge counters, so they all lag by exactly one advance.
      bus.de          <= w_de;
      bus.x           <= w_de ? r_h_cnt[XW-1:0] : '0;
      bus.y           <= w_de ? r_v_cnt[YW-1:0] : '0;
      bus.hsync       <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      bus.vsync       <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      bus.line_start  <= w_de && (r_h_cnt == 10'd0);
      bus.frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    end
  end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// tb/tb_dvi_timing_gen.sv - randomized bench for dvi_timing_gen against a raster-position model
module tb_dvi_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit POL = 1'b0;

  logic clk;
  logic rst_n;
  logic ce;

  dvi_timing_gen_if bus ();

`ifdef DVI_TIMING_PIXEL_CE_EN
  assign bus.pix_ce = ce;
`endif

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pos      = 0;
  int e_x, e_y, e_de, e_hs, e_vs, e_ls, e_fs;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d (t=%0t pos=%0d)", tag, got, exp, $time, pos);
  endtask

  task automatic model_reset();
    pos  = 0;
    e_x  = 0; e_y = 0; e_de = 0; e_ls = 0; e_fs = 0;
    e_hs = !POL; e_vs = !POL;
  endtask

  // Expected outputs for raster position p: column/row recovered by division.
  task automatic model_decode(input int p);
    int hc, vc;
    hc   = p % HT;
    vc   = p / HT;
    e_de = (hc < HA && vc < VA) ? 1 : 0;
    e_x  = e_de ? hc : 0;
    e_y  = e_de ? vc : 0;
    e_hs = (hc >= HA + HF && hc < HA + HF + HS) ? POL : !POL;
    e_vs = (vc >= VA + VF && vc < VA + VF + VS) ? POL : !POL;
    e_ls = (e_de && hc == 0) ? 1 : 0;
    e_fs = (p == 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    chk("x", int'(bus.x), e_x);
    chk("y", int'(bus.y), e_y);
    chk("de", int'(bus.de), e_de);
    chk("hsync", int'(bus.hsync), e_hs);
    chk("vsync", int'(bus.vsync), e_vs);
    chk("line_start", int'(bus.line_start), e_ls);
    chk("frame_start", int'(bus.frame_start), e_fs);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ce) begin
      model_decode(pos);
      pos = (pos + 1) % FRAME;
    end
    #1;
    compare_all();
  endtask

  task automatic pick_ce();
`ifdef DVI_TIMING_PIXEL_CE_EN
    ce = 1'($urandom_range(0, 1));
`else
    ce = 1'b1;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    model_reset();
    repeat (3) step();
    #2 rst_n = 1'b1;

    // Two full frames at one pixel per clock, covering both frame wraps.
    repeat (2 * FRAME + 40) step();

    // Random run lengths, random pixel enable, asynchronous resets mid-frame.
    for (int i = 0; i < 6; i++) begin
      int len;
      len = $urandom_range(20, FRAME + 100);
      for (int k = 0; k < len; k++) begin
        pick_ce();
        step();
      end
      ce = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat ($urandom_range(1, 3)) step();
      #2 rst_n = 1'b1;
    end

`ifdef DVI_TIMING_PIXEL_CE_EN
    // Strict alternation: one advance per two clocks.
    for (int k = 0; k < 4 * HT; k++) begin
      ce = 1'(k % 2 == 0);
      step();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
